// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the fetch PC and issues word requests over a req/gnt/rvalid port.
// Returned words are buffered with their PCs in a small FIFO whose head is
// presented to decode. A redirect from execute flushes the FIFO and drops
// every response still in flight for the wrong path.
// Optional build macro: FETCH_PERF_CNT_EN adds bubble and redirect counters.
//
// Handshake rules for the memory side:
//   a request transfers on a cycle where imem_req && imem_gnt; responses
//   come back in order, one per imem_rvalid cycle, no earlier than the cycle
//   after the grant. The decode side pops the head on validF && !stallF.
module fetch_stage #(
    parameter int             DPW        = 32,
    parameter logic [DPW-1:0] RESET_PC   = '0,
    parameter int             FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallF,
    input  logic           PCSrcE,
    input  logic [DPW-1:0] PCTargetE,
    output logic           imem_req,
    output logic [DPW-1:0] imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [DPW-1:0] imem_rdata,
    output logic [DPW-1:0] instrF,
    output logic [DPW-1:0] PCF,
    output logic           validF,
    output logic           fetch_empty,
    output logic [1:0]     fsm_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]    fetch_bubble_cnt,
    output logic [31:0]    redirect_cnt
`endif
);

    localparam int             PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             CW  = PW + 1;
    localparam logic [CW:0]    CAP = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DPW-1:0] NOP = DPW'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1
    } state_t;

    state_t          state_q;
    logic [DPW-1:0]  pc_q;
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   disc_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [DPW-1:0]  fifo_pc_q    [FIFO_DEPTH];
    logic [DPW-1:0]  fifo_instr_q [FIFO_DEPTH];

    logic            grant;
    logic            push;
    logic            pop;
    logic [CW-1:0]   rvalid_w;
    logic [CW-1:0]   redir_disc_d;
    logic [DPW-1:0]  redir_pc_d;
    logic [DPW-1:0]  inflight_pc;
    logic            unused_tgt_lsb;

    // Requests are capped so outstanding plus buffered words never exceed the
    // FIFO, which is what makes an unconditional push on rvalid safe.
    assign imem_req  = (state_q == ST_FETCH) && !rst && !PCSrcE &&
                       (({1'b0, out_q} + {1'b0, cnt_q}) < CAP);
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    // Responses are in order, so the oldest in-flight word belongs to the
    // PC that sits 'outstanding' words behind the fetch PC (mod 2^DPW).
    assign inflight_pc = pc_q - DPW'({out_q, 2'b00});

    assign push = imem_rvalid && (state_q == ST_FETCH) && !PCSrcE;
    assign pop  = (cnt_q != '0) && !stallF && !PCSrcE;

    // On a redirect every word still owed by memory is wrong-path; one that
    // returns in the redirect cycle itself is already dropped.
    assign rvalid_w       = CW'(imem_rvalid);
    assign redir_disc_d   = ((state_q == ST_FETCH) ? out_q : disc_q) - rvalid_w;
    assign redir_pc_d     = {PCTargetE[DPW-1:2], 2'b00};
    assign unused_tgt_lsb = ^PCTargetE[1:0];

    // Fetch PC, outstanding/discard counters and FETCH/FLUSH control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
        end else if (PCSrcE) begin
            pc_q    <= redir_pc_d;
            out_q   <= '0;
            disc_q  <= redir_disc_d;
            state_q <= (redir_disc_d != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (grant) begin
                        pc_q <= pc_q + DPW'(4);
                    end
                    out_q <= out_q + CW'(grant) - rvalid_w;
                end
                ST_FLUSH: begin
                    if (imem_rvalid) begin
                        disc_q <= disc_q - CW'(1);
                        if (disc_q == CW'(1)) begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Instruction buffer: pointer-based FIFO of {pc, instr}, emptied on redirect.
    always_ff @(posedge clk) begin
        if (rst || PCSrcE) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_q]    <= inflight_pc;
                fifo_instr_q[wr_q] <= imem_rdata;
                wr_q               <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign validF      = (cnt_q != '0);
    assign fetch_empty = !validF;
    assign instrF      = validF ? fifo_instr_q[rd_q] : NOP;
    assign PCF         = validF ? fifo_pc_q[rd_q] : '0;
    assign fsm_state   = state_q;

`ifdef FETCH_PERF_CNT_EN
    // Bubble counter saturates; redirect counter counts every PCSrcE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_bubble_cnt <= '0;
            redirect_cnt     <= '0;
        end else begin
            if (!validF && (fetch_bubble_cnt != 32'hFFFF_FFFF)) begin
                fetch_bubble_cnt <= fetch_bubble_cnt + 32'd1;
            end
            if (PCSrcE) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

    // A response is only legal while a word is owed in the current state.
    rvalid_legal_a: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((state_q == ST_FETCH) ? (out_q != '0) : (disc_q != '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage (RESET_PC=0x100, depth 2).
// Memory model grants as told by the driver and answers one cycle after
// each grant with rdata = addr ^ 0x5A00_0000 unless responses are held.
// Expected {PC, instr} pairs are pushed by the driver; a monitor pops and
// compares on every cycle the DUT hands a word to decode.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic        validF;
    logic        fetch_empty;
    logic [1:0]  fsm_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_bubble_cnt;
    logic [31:0] redirect_cnt;
    int          tb_bubbles = 0;
    int          tb_redirs  = 0;
`endif

    logic        resp_hold;
    logic [31:0] gq[$];
    logic [63:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    fetch_stage #(.DPW(32), .RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instrF      (instrF),
        .PCF         (PCF),
        .validF      (validF),
        .fetch_empty (fetch_empty),
        .fsm_state   (fsm_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_bubble_cnt (fetch_bubble_cnt),
        .redirect_cnt     (redirect_cnt)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    task automatic chk_empty_outputs(input string tag);
        chk({tag, "_validF"}, {31'd0, validF}, 32'd0);
        chk({tag, "_fetch_empty"}, {31'd0, fetch_empty}, 32'd1);
        chk({tag, "_instrF"}, instrF, NOP);
        chk({tag, "_PCF"}, PCF, 32'd0);
    endtask

    // Memory model: capture grants mid-cycle, answer in the following cycle
    always @(negedge clk) begin
        if (rst) gq.delete();
        else if (imem_req && imem_gnt) gq.push_back(imem_addr);
    end

    always @(posedge clk) begin
        #2;
        if (!rst && !resp_hold && gq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = gq.pop_front() ^ 32'h5A00_0000;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // Scoreboard monitor: every word accepted by decode must be the next expected one
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && validF && !stallF && !PCSrcE) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got PCF=%h instrF=%h expected none", PCF, instrF);
            end else begin
                e = exp_q.pop_front();
                chk("pop_PCF", PCF, e[63:32]);
                chk("pop_instrF", instrF, e[31:0]);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        if (rst) begin
            tb_bubbles = 0;
            tb_redirs  = 0;
        end else begin
            if (!validF) tb_bubbles++;
            if (PCSrcE) tb_redirs++;
        end
`endif
    end

    // Directed stimulus
    initial begin
        rst = 1'b1; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_gnt = 1'b1; resp_hold = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);
        chk_empty_outputs("rst");

        // Streaming from RESET_PC with gnt high for six cycles
        step(); rst = 1'b0;
        exp_push(32'h0000_0100, 32'h5A00_0100);
        exp_push(32'h0000_0104, 32'h5A00_0104);
        exp_push(32'h0000_0108, 32'h5A00_0108);
        exp_push(32'h0000_010C, 32'h5A00_010C);
        @(negedge clk);
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0000_0100);
        chk("c0_validF", {31'd0, validF}, 32'd0);
        step();
        @(negedge clk);
        chk("c1_addr", imem_addr, 32'h0000_0104);
        chk("c1_validF", {31'd0, validF}, 32'd0);
        step();
        @(negedge clk);
        chk("c2_validF", {31'd0, validF}, 32'd1);
        chk("c2_req_capped", {31'd0, imem_req}, 32'd0);
        repeat (3) step();

        // gnt held low: request stays up with a stable address, FIFO drains
        step(); imem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("nognt_req", {31'd0, imem_req}, 32'd1);
            chk("nognt_addr", imem_addr, 32'h0000_0110);
        end
        chk_empty_outputs("nognt");

        // Stall for five cycles: FIFO fills, requests stop, head holds
        step(); stallF = 1'b1; imem_gnt = 1'b1;
        exp_push(32'h0000_0110, 32'h5A00_0110);
        exp_push(32'h0000_0114, 32'h5A00_0114);
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_validF", {31'd0, validF}, 32'd1);
            chk("stall_PCF", PCF, 32'h0000_0110);
            chk("stall_instrF", instrF, 32'h5A00_0110);
        end
        step(); stallF = 1'b0; imem_gnt = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("post_stall_validF", {31'd0, validF}, 32'd0);
        chk("post_stall_addr", imem_addr, 32'h0000_0118);

        // Two outstanding, redirect to 0x203, both late responses dropped
        step(); resp_hold = 1'b1; imem_gnt = 1'b1;
        step();
        step(); PCSrcE = 1'b1; PCTargetE = 32'h0000_0203;
        @(negedge clk);
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        step(); PCSrcE = 1'b0; resp_hold = 1'b0;
        exp_push(32'h0000_0200, 32'h5A00_0200);
        @(negedge clk);
        chk("flush1_state", {30'd0, fsm_state}, 32'd1);
        chk("flush1_req", {31'd0, imem_req}, 32'd0);
        step();
        @(negedge clk);
        chk("flush2_state", {30'd0, fsm_state}, 32'd1);
        chk("flush2_req", {31'd0, imem_req}, 32'd0);
        step();
        @(negedge clk);
        chk("refetch_state", {30'd0, fsm_state}, 32'd0);
        chk("refetch_addr", imem_addr, 32'h0000_0200);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        step(); imem_gnt = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("after200_validF", {31'd0, validF}, 32'd0);
        chk("after200_addr", imem_addr, 32'h0000_0204);

        // Redirect in the same cycle as the only response
        step(); imem_gnt = 1'b1;
        step(); imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
        @(negedge clk);
        chk("samecyc_req", {31'd0, imem_req}, 32'd0);
        step(); PCSrcE = 1'b0; imem_gnt = 1'b1;
        exp_push(32'h0000_0300, 32'h5A00_0300);
        @(negedge clk);
        chk("samecyc_state", {30'd0, fsm_state}, 32'd0);
        chk("samecyc_addr", imem_addr, 32'h0000_0300);
        chk("samecyc_req_next", {31'd0, imem_req}, 32'd1);
        chk("samecyc_validF", {31'd0, validF}, 32'd0);
        step(); imem_gnt = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("after300_addr", imem_addr, 32'h0000_0304);

        // PC wrap: redirect to 0xFFFF_FFFF (low bits cleared), then 0xFFFF_FFFC -> 0
        step(); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        exp_push(32'hFFFF_FFFC, 32'hA5FF_FFFC);
        exp_push(32'h0000_0000, 32'h5A00_0000);
        step(); PCSrcE = 1'b0; imem_gnt = 1'b1;
        @(negedge clk);
        chk("wrap_state", {30'd0, fsm_state}, 32'd0);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        chk("wrap_req1", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        step(); imem_gnt = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("wrap_drained", {31'd0, validF}, 32'd0);
        chk("wrap_addr2", imem_addr, 32'h0000_0004);

        step();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_bubbles", fetch_bubble_cnt, 32'(tb_bubbles));
        chk("perf_redirects", redirect_cnt, 32'(tb_redirs));
`endif

        // Reset mid-operation with a full, stalled FIFO
        stallF = 1'b1; imem_gnt = 1'b1;
        repeat (3) step();
        step(); rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_state", {30'd0, fsm_state}, 32'd0);
        chk_empty_outputs("midrst");
        step(); rst = 1'b0; stallF = 1'b0; imem_gnt = 1'b0;
        @(negedge clk);
        chk("midrst_addr", imem_addr, 32'h0000_0100);
        chk("midrst_req_after", {31'd0, imem_req}, 32'd1);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline. Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions with their PCs in a small FIFO and presents the head entry as instrF/PCF to the decode pipeline register.
- Handles redirect from execute (taken branch/jump) by discarding wrong-path words.

Parameters:
- DPW, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding + buffered words (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- stallF  input  1  hazard unit hold: do not pop the FIFO head this cycle.
- PCSrcE  input  1  redirect request from execute.
- PCTargetE  input  DPW  redirect target.
- imem_req  output  1  memory request valid.
- imem_addr  output  DPW  request word address; bits[1:0] are always 0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata  input  DPW  response instruction.
- instrF  output  DPW  head instruction; NOP 32'h0000_0013 when validF=0.
- PCF  output  DPW  PC of head instruction; 0 when validF=0.
- validF  output  1  FIFO non-empty.
- fetch_empty  output  1  equals !validF; fed to the hazard unit to stall decode.

Behaviour:
- **Clock/reset:** one clock (clk); reset rst is synchronous, active-high.
- **Reset values:** pc_q=RESET_PC, state=FETCH, FIFO empty, outstanding=0, imem_req=0 in the reset cycle, instrF=NOP, PCF=0, validF=0, fetch_empty=1.
- **Registers:** pc_q, 2-bit state, FIFO of {pc,instr}, outstanding counter (0..FIFO_DEPTH), discard counter.
- **State FETCH:**
  - imem_req=1 iff !rst && !PCSrcE && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_addr = pc_q.
  - On req && gnt: outstanding+1; push the request PC into the in-flight PC queue; pc_q += 4, wrapping 32'hFFFF_FFFC -> 0.
- **Response in FETCH:** on rvalid, push {inflight_pc, imem_rdata} to the FIFO and decrement outstanding. The FIFO cannot overflow because of the request cap.
- **Pop:** when validF && !stallF. Pop and push in the same cycle are legal and leave the count unchanged.
- **Output timing:**
  - instrF/PCF/validF are registered FIFO-head values, valid the cycle after the push.
  - Minimum latency from gnt to validF is 2 cycles (rvalid next cycle, then visible).
- **Redirect (PCSrcE=1, any state, overrides stallF):**
  - FIFO flushed at the clock edge; pc_q <= {PCTargetE[DPW-1:2],2'b00}; no request issued that cycle.
  - discard <= outstanding minus any rvalid in the same cycle.
  - Next state: FLUSH if the new discard > 0, else FETCH.
- **State FLUSH:**
  - imem_req=0.
  - Each rvalid decrements discard and is dropped, not pushed.
  - discard reaching 0 -> FETCH.
  - A second PCSrcE in FLUSH reloads pc_q and stays in FLUSH.
- **Simultaneous events:**
  - rvalid in the redirect cycle is dropped.
  - A gnt in the redirect cycle is impossible, since req is 0.
  - A stall with an empty FIFO has no effect.
- **Reset mid-operation:** all state cleared. Instruction memory shares rst, so no stale responses arrive after reset.
- **Forbidden inputs:** rvalid with outstanding=0 (FETCH) or discard=0 (FLUSH) is illegal; assertion only, no RTL handling.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_bubble_cnt [31:0], reset to 0.
  - Increments (saturating at 32'hFFFF_FFFF) every cycle validF=0 && !rst.
  - Adds output redirect_cnt [31:0], incremented on each PCSrcE cycle.
- Undefined: neither port nor counter exists; functionality otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h100, gnt=1 always, rvalid 1 cycle after gnt, stallF=0 -> addresses 100,104,108... issued; PCF sequence 100,104,108 with matching instrF; validF first high 3 cycles after rst falls.
- stallF=1 for 5 cycles with FIFO_DEPTH=2 -> FIFO fills with 2 entries; imem_req drops to 0; instrF/PCF hold; after release, order is preserved and no word is lost or duplicated.
- Two requests outstanding, then PCSrcE=1 with PCTargetE=32'h203 -> pc_q=32'h200; FSM enters FLUSH; both late responses dropped; next PCF=32'h200.
- PCSrcE in the same cycle as rvalid, outstanding=1 -> response dropped; discard=0; state FETCH; next request addr = target.
- gnt held low for 4 cycles -> imem_req stays 1 with a stable address; validF=0, fetch_empty=1, instrF=32'h0000_0013.
- pc_q=32'hFFFF_FFFC granted -> next request addr 32'h0000_0000. With FETCH_PERF_CNT_EN, fetch_bubble_cnt counts exactly the validF=0 cycles.
